// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register.
// A WIDTH-bit word is captured while sel=0 and streamed out MSB first,
// one bit per rising clk edge, while sel=1. The LSB is zero-filled, so
// after WIDTH shifts the output stays low until the next load.
// There is no handshake: the consumer counts WIDTH edges on its own.
// clr is an asynchronous, active-high clear with priority over everything.
module piso_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             sel,
   output logic             q
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Next-state select: load only on an explicit sel==0, anything else shifts
   always_comb begin
      sr_d = sr_q;
      if (sel == 1'b0) begin
         sr_d = d;
      end else begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   // Shift register state with asynchronous clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   // Serial output is the register MSB, never a combinational path from d
   assign q = sr_q[WIDTH-1];

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg. The reference model keeps the
// bits still to be emitted in a queue (MSB first); q is expected to be the
// head of that queue, or 0 once it has drained or after a clear.
module tb_piso_shift_reg;

  localparam int W = 4;

  logic         clk;
  logic         clr;
  logic [W-1:0] d_in;
  logic         sel;
  logic         q;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  logic exp_q[$];

  piso_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .d   (d_in),
    .sel (sel),
    .q   (q)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic void model_load(input logic [W-1:0] word);
    exp_q.delete();
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
  endfunction

  function automatic void model_shift();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endfunction

  function automatic void model_clear();
    exp_q.delete();
  endfunction

  function automatic logic model_q();
    return (exp_q.size() > 0) ? exp_q[0] : 1'b0;
  endfunction

  // scoreboard compare
  task automatic check(input string tag);
    logic exp;
    exp = model_q();
    cmp_cnt++;
    assert (q === exp) else begin
      fail_cnt++;
      $error("FAIL %s: q=%b expected %b", tag, q, exp);
    end
  endtask

  // driver tasks (called at posedge+1, inputs change away from the edge)
  task automatic edge_load(input logic [W-1:0] word, input string tag);
    sel  = 1'b0;
    d_in = word;
    @(posedge clk);
    model_load(word);
    #1;
    check(tag);
  endtask

  task automatic edge_shift(input string tag);
    sel  = 1'b1;
    d_in = W'($urandom);
    @(posedge clk);
    model_shift();
    #1;
    check(tag);
  endtask

  task automatic edge_clr_held(input logic s, input string tag);
    sel  = s;
    d_in = '1;
    @(posedge clk);
    model_clear();
    #1;
    check(tag);
  endtask

  // half-cycle clear pulse placed between edges
  task automatic pulse_clear(input string tag);
    #1;
    clr = 1'b1;
    model_clear();
    #1;
    check({tag, "_async"});
    #4;
    clr = 1'b0;
    #1;
    check({tag, "_release"});
  endtask

  initial begin
    logic [W-1:0] word;
    clr  = 1'b0;
    sel  = 1'b1;
    d_in = '1;
    #2;
    clr = 1'b1;
    model_clear();
    #1;
    check("reset_state");
    // clear held across edges with sel=1 and sel=0, d=1111
    edge_clr_held(1'b1, "clr_hold_shift");
    edge_clr_held(1'b0, "clr_hold_load");
    edge_clr_held(1'b1, "clr_hold_shift2");
    #2;
    clr = 1'b0;
    #1;
    check("clr_release");

    // asynchronous drop of q between edges
    edge_load(4'b1111, "pre_clr_load");
    pulse_clear("clr_between_edges");

    // load/shift 0100
    edge_load(4'b0100, "ld0100");
    for (int i = 0; i < 6; i++) edge_shift($sformatf("sh0100_%0d", i));

    // load/shift 1110, then zero fill with no wrap
    edge_load(4'b1110, "ld1110");
    for (int i = 0; i < 10; i++) edge_shift($sformatf("sh1110_%0d", i));

    // back-to-back loads
    edge_load(4'b1000, "b2b_ld1000");
    edge_load(4'b0111, "b2b_ld0111");
    for (int i = 0; i < 5; i++) edge_shift($sformatf("b2b_sh_%0d", i));

    // abort mid-stream and reload
    edge_load(4'b1010, "abort_ld1010");
    edge_shift("abort_sh0");
    edge_shift("abort_sh1");
    edge_load(4'b0001, "abort_ld0001");
    for (int i = 0; i < 4; i++) edge_shift($sformatf("abort_resh_%0d", i));

    // clear mid-shift
    edge_load(4'b1111, "mid_ld1111");
    edge_shift("mid_sh0");
    pulse_clear("mid_clr");
    for (int i = 0; i < 4; i++) edge_shift($sformatf("mid_post_%0d", i));

    // randomized mix of loads, shifts and clear pulses
    for (int i = 0; i < 200; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 3) begin
        word = W'($urandom);
        edge_load(word, $sformatf("rnd_ld_%0d", i));
      end else if (op < 9) begin
        edge_shift($sformatf("rnd_sh_%0d", i));
      end else begin
        pulse_clear($sformatf("rnd_clr_%0d", i));
      end
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
